// File: rtl/reg_file_renamed_pkg.sv
// Shared constants and types for the renamed register file.
// Widths for register index, ROB tag and data, plus the tag-update bundle.
package reg_file_renamed_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROB_TAG_W = 4;
    localparam int ROB_SIZE_W = 4;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

    typedef logic [XLEN-1:0]      xword_t;
    typedef logic [REG_IDX_W-1:0] ridx_t;
    typedef logic [ROB_TAG_W-1:0] rtag_t;

    typedef struct packed {
        logic  valid;
        ridx_t idx;
        rtag_t tag;
    } tag_upd_t;

    function automatic logic idx_live(ridx_t i);
        return i != '0;
    endfunction

endpackage

// File: rtl/reg_file_renamed_reg_status_table.sv
// Rename-tag table: one pending ROB tag per register (0 = ready).
// Ports: clk_i/rst_ni, en_i hold, rename/clear updates, flush, 2 tag reads.
module reg_status_table
    import reg_file_renamed_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 ren_valid_i,
    input  logic [REG_IDX_W-1:0] ren_idx_i,
    input  logic [ROB_TAG_W-1:0] ren_tag_i,
    input  logic                 clr_valid_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic [ROB_TAG_W-1:0] clr_tag_i,
    input  logic                 flush_i,
    input  logic [REG_IDX_W-1:0] rd1_idx_i,
    output logic [ROB_TAG_W-1:0] rd1_tag_o,
    input  logic [REG_IDX_W-1:0] rd2_idx_i,
    output logic [ROB_TAG_W-1:0] rd2_tag_o
);

    rtag_t    tags_q [NUM_REGS];
    rtag_t    tags_d [NUM_REGS];
    tag_upd_t ren;
    tag_upd_t clr;

    assign ren = '{valid: ren_valid_i, idx: ren_idx_i, tag: ren_tag_i};
    assign clr = '{valid: clr_valid_i, idx: clr_idx_i, tag: clr_tag_i};

    // Clear only if the tag still names the committing entry; a
    // younger rename must survive. Rename is applied last so it wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            tags_d[i] = tags_q[i];
        end
        if (en_i) begin
            if (clr.valid && idx_live(clr.idx)
                && tags_q[clr.idx] == clr.tag) begin
                tags_d[clr.idx] = TAG_NONE;
            end
            if (flush_i) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    tags_d[i] = TAG_NONE;
                end
            end else if (ren.valid && idx_live(ren.idx)) begin
                tags_d[ren.idx] = ren.tag;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tags_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tags_q[i] <= tags_d[i];
            end
        end
    end

    assign rd1_tag_o = tags_q[rd1_idx_i];
    assign rd2_tag_o = tags_q[rd2_idx_i];

endmodule

// File: rtl/reg_file_renamed.sv
// Architectural register file with rename tags and CDB commit/bypass.
// Ports: rename (issue), rs1/rs2 {val,tag} reads, CDB commit, flush, count.
module reg_file_renamed
    import reg_file_renamed_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rename_valid,
    input  logic [REG_IDX_W-1:0] rename_rd_idx,
    input  logic [ROB_TAG_W-1:0] rename_tag,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]      rs1_val,
    output logic [ROB_TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]      rs2_val,
    output logic [ROB_TAG_W-1:0] rs2_tag,
    input  logic                 cdb_active,
    input  logic [ROB_TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]      cdb_val,
    input  logic [REG_IDX_W-1:0] cdb_rd_idx,
    input  logic                 predict_fail,
    output logic [31:0]          commit_count
);

    xword_t      regs_q [NUM_REGS];
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        commit;
    rtag_t       t1_raw;
    rtag_t       t2_raw;
    logic        byp1;
    logic        byp2;

    assign commit = cdb_active && (cdb_tag != TAG_NONE)
                    && idx_live(cdb_rd_idx);

    reg_status_table u_status (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .en_i        (rdy_in),
        .ren_valid_i (rename_valid),
        .ren_idx_i   (rename_rd_idx),
        .ren_tag_i   (rename_tag),
        .clr_valid_i (commit),
        .clr_idx_i   (cdb_rd_idx),
        .clr_tag_i   (cdb_tag),
        .flush_i     (predict_fail),
        .rd1_idx_i   (rs1_idx),
        .rd1_tag_o   (t1_raw),
        .rd2_idx_i   (rs2_idx),
        .rd2_tag_o   (t2_raw)
    );

    assign cnt_d = cnt_q + 32'd1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (rdy_in && commit) begin
            regs_q[cdb_rd_idx] <= cdb_val;
            cnt_q              <= cnt_d;
        end
    end

    // Forward the committing value only to a reader still waiting on
    // exactly that producer; commit already excludes x0.
    assign byp1 = commit && rs1_idx == cdb_rd_idx && t1_raw == cdb_tag;
    assign byp2 = commit && rs2_idx == cdb_rd_idx && t2_raw == cdb_tag;

    always_comb begin
        rs1_val = regs_q[rs1_idx];
        rs1_tag = t1_raw;
        if (!idx_live(rs1_idx)) begin
            rs1_val = '0;
            rs1_tag = TAG_NONE;
        end else if (byp1) begin
            rs1_val = cdb_val;
            rs1_tag = TAG_NONE;
        end
    end

    always_comb begin
        rs2_val = regs_q[rs2_idx];
        rs2_tag = t2_raw;
        if (!idx_live(rs2_idx)) begin
            rs2_val = '0;
            rs2_tag = TAG_NONE;
        end else if (byp2) begin
            rs2_val = cdb_val;
            rs2_tag = TAG_NONE;
        end
    end

    assign commit_count = cnt_q;

endmodule
